// File: rtl/cobi_pkg.sv
// -----------------------------------------------------------------------------
// cobi_pkg
// Shared definitions for the COBI oscillator-array sequencer: FSM state
// encoding, chip bus widths, scan-chain geometry and counter widths.
// No ports (package).
// -----------------------------------------------------------------------------
package cobi_pkg;

  localparam int COBI_CHAIN_LEN  = 504;  // bits in the chip scan chain
  localparam int COBI_ADDR_W     = 6;    // row / column address width
  localparam int COBI_WEIGHT_W   = 6;    // weight value width
  localparam int COBI_RES_W      = 8;    // result word width
  localparam int COBI_NUM_BYTES  = COBI_CHAIN_LEN / COBI_RES_W;  // 63
  localparam int COBI_BIT_IDX_W  = 9;    // holds 0..503
  localparam int COBI_BYTE_CNT_W = 6;    // holds 0..62
  localparam int COBI_BIT_SEL_W  = $clog2(COBI_RES_W);

  localparam logic [COBI_BIT_IDX_W-1:0]  COBI_LAST_BIT  = COBI_BIT_IDX_W'(COBI_CHAIN_LEN - 1);
  localparam logic [COBI_BYTE_CNT_W-1:0] COBI_LAST_BYTE = COBI_BYTE_CNT_W'(COBI_NUM_BYTES - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_RUN,
    ST_SAMPLE,
    ST_SCAN_LO,
    ST_SCAN_HI,
    ST_EMIT
  } cobi_state_e;

  // The weight bus is owned (and o_WEIGHT_EN asserted) in these states.
  function automatic logic is_write_state(cobi_state_e s);
    return (s == ST_WR_SETUP) || (s == ST_WR_STROBE) || (s == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/cobi_sequencer_if.sv
// -----------------------------------------------------------------------------
// cobi_sequencer_if
// Host-side bundle of the sequencer: weight-write handshake, run request /
// busy flag and the result byte stream. Signal names keep the sequencer's
// point of view (i_* enter the sequencer, o_* leave it).
//   modport master : host register logic (drives i_*, observes o_*)
//   modport slave  : cobi_sequencer
// -----------------------------------------------------------------------------
interface cobi_sequencer_if;
  import cobi_pkg::*;

  logic                      i_WR_VALID;
  logic                      o_WR_READY;
  logic [COBI_ADDR_W-1:0]    i_WR_ROW;
  logic [COBI_ADDR_W-1:0]    i_WR_COL;
  logic [COBI_WEIGHT_W-1:0]  i_WR_DATA;
  logic                      i_START;
  logic                      o_BUSY;
  logic [COBI_RES_W-1:0]     o_RES_DATA;
  logic                      o_RES_VALID;
  logic                      i_RES_READY;
  logic                      o_RES_LAST;

  modport master (
    output i_WR_VALID, i_WR_ROW, i_WR_COL, i_WR_DATA, i_START, i_RES_READY,
    input  o_WR_READY, o_BUSY, o_RES_DATA, o_RES_VALID, o_RES_LAST
  );

  modport slave (
    input  i_WR_VALID, i_WR_ROW, i_WR_COL, i_WR_DATA, i_START, i_RES_READY,
    output o_WR_READY, o_BUSY, o_RES_DATA, o_RES_VALID, o_RES_LAST
  );

endinterface

// File: rtl/cobi_scan_deser.sv
// -----------------------------------------------------------------------------
// cobi_scan_deser
// Scan-chain deserialiser: captures one chip scan bit per capture strobe into
// the selected bit of an 8-bit word, and on the emit strobe copies the word
// into a valid/ready output stage that holds it until accepted.
// Ports:
//   clk_i, rstn_i      clock, synchronous active-low reset
//   capture_i          sample dout_i into bit bit_sel_i this cycle
//   bit_sel_i [2:0]    destination bit (chain index mod 8)
//   dout_i             chip scan-chain output
//   load_i             present the assembled word on the stream
//   last_i             word being loaded is the final one of the run
//   ready_i            downstream ready
//   data_o/valid_o/last_o  result stream (registered)
//   accept_o           handshake this cycle (valid_o & ready_i)
// -----------------------------------------------------------------------------
module cobi_scan_deser
  import cobi_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      capture_i,
  input  logic [COBI_BIT_SEL_W-1:0] bit_sel_i,
  input  logic                      dout_i,
  input  logic                      load_i,
  input  logic                      last_i,
  input  logic                      ready_i,
  output logic [COBI_RES_W-1:0]     data_o,
  output logic                      valid_o,
  output logic                      last_o,
  output logic                      accept_o
);

  logic [COBI_RES_W-1:0] shift_w;
  logic [COBI_RES_W-1:0] data_q;
  logic                  valid_q;
  logic                  last_q;

  // One flop per word bit; every bit is rewritten each byte, so no clearing
  // is needed between words.
  for (genvar gi = 0; gi < COBI_RES_W; gi++) begin : g_bit
    logic bit_q;
    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        bit_q <= 1'b0;
      end else if (capture_i && (bit_sel_i == COBI_BIT_SEL_W'(gi))) begin
        bit_q <= dout_i;
      end
    end
    assign shift_w[gi] = bit_q;
  end

  assign accept_o = valid_q & ready_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      data_q  <= shift_w;
      valid_q <= 1'b1;
      last_q  <= last_i;
    end else if (accept_o) begin
      // Data is left in place; only the qualifiers drop.
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: rtl/cobi_sequencer.sv
// -----------------------------------------------------------------------------
// cobi_sequencer
// Drives the COBI chip programming, run and scan-out pins. Accepts weight
// writes and run requests from the host, sequences latch strobes, ROSC
// enable, sample pulse and scan clock, and returns the 504-bit scan chain as
// 63 bytes on a valid/ready stream. Every chip pin comes straight from a flop.
// Parameters:
//   WR_PULSE      cycles o_ADDR_EN64 is high per write
//   RUN_CYCLES    cycles o_ROSC_EN is high before sampling
//   SAMPLE_PULSE  cycles o_SAMPLE_CLK is high
//   SCAN_HALF     cycles per half period of o_SCANOUT_CLK
// Ports:
//   i_CLK, i_RSTN        clock, synchronous active-low reset
//   host                 cobi_sequencer_if.slave (writes, start/busy, results)
//   o_ROW_ADDR/o_COL_ADDR/o_WEIGHT   chip weight bus
//   o_ADDR_EN64, o_WEIGHT_EN, o_ROSC_EN, o_SAMPLE_CLK, o_SCANOUT_CLK,
//   o_ALL_ROW_HI         chip controls
//   i_SCANOUT_DOUT64     chip scan-chain output
// -----------------------------------------------------------------------------
module cobi_sequencer
  import cobi_pkg::*;
#(
  parameter int unsigned WR_PULSE     = 2,
  parameter int unsigned RUN_CYCLES   = 1000,
  parameter int unsigned SAMPLE_PULSE = 2,
  parameter int unsigned SCAN_HALF    = 2
) (
  input  logic                     i_CLK,
  input  logic                     i_RSTN,
  cobi_sequencer_if.slave          host,
  output logic [COBI_ADDR_W-1:0]   o_ROW_ADDR,
  output logic [COBI_ADDR_W-1:0]   o_COL_ADDR,
  output logic [COBI_WEIGHT_W-1:0] o_WEIGHT,
  output logic                     o_ADDR_EN64,
  output logic                     o_WEIGHT_EN,
  output logic                     o_ROSC_EN,
  output logic                     o_SAMPLE_CLK,
  output logic                     o_SCANOUT_CLK,
  output logic                     o_ALL_ROW_HI,
  input  logic                     i_SCANOUT_DOUT64
);

  localparam logic [31:0] WR_LAST     = 32'(WR_PULSE - 1);
  localparam logic [31:0] RUN_LAST    = 32'(RUN_CYCLES - 1);
  localparam logic [31:0] SAMPLE_LAST = 32'(SAMPLE_PULSE - 1);
  localparam logic [31:0] HALF_LAST   = 32'(SCAN_HALF - 1);

  cobi_state_e                 state_q, state_d;
  logic [31:0]                 cnt_q, cnt_d;        // cycles spent in current timed state
  logic [COBI_BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [COBI_BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

  logic [COBI_ADDR_W-1:0]      row_q, col_q;
  logic [COBI_WEIGHT_W-1:0]    weight_q;
  logic                        wr_ready_q, busy_q;
  logic                        addr_en_q, weight_en_q, rosc_en_q, sample_clk_q, scan_clk_q;

  logic                        wr_accept;
  logic                        capture;
  logic                        load;
  logic                        res_accept;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    wr_accept  = 1'b0;
    capture    = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A write in the same cycle as a start wins; the start is dropped.
        if (host.i_WR_VALID && wr_ready_q) begin
          wr_accept = 1'b1;
          state_d   = ST_WR_SETUP;
          cnt_d     = '0;
        end else if (host.i_START) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          bit_idx_d  = '0;
          byte_cnt_d = '0;
        end
      end

      ST_WR_SETUP: begin
        state_d = ST_WR_STROBE;
        cnt_d   = '0;
      end

      ST_WR_STROBE: begin
        if (cnt_q == WR_LAST) begin
          state_d = ST_WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_WR_HOLD: begin
        state_d = ST_IDLE;
      end

      ST_RUN: begin
        if (cnt_q == RUN_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          state_d   = ST_SCAN_LO;
          cnt_d     = '0;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_SCAN_LO: begin
        // Sample the chain at the end of the low phase, just before the
        // rising scan edge advances it.
        if (cnt_q == HALF_LAST) begin
          capture = 1'b1;
          state_d = ST_SCAN_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_SCAN_HI: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = (bit_idx_q == COBI_LAST_BIT) ? '0 : bit_idx_q + 1'b1;
          // Eighth bit of the byte just completed -> hand the byte out.
          if (bit_idx_q[COBI_BIT_SEL_W-1:0] == '1) begin
            load    = 1'b1;
            state_d = ST_EMIT;
          end else begin
            state_d = ST_SCAN_LO;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_EMIT: begin
        // Scan clock stays low here, so backpressure simply pauses the chain.
        if (res_accept) begin
          if (byte_cnt_q == COBI_LAST_BYTE) begin
            state_d = ST_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = ST_SCAN_LO;
            cnt_d      = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and pin registers. Pin values are decoded from state_d so that each
  // pin flop lines up with the state it belongs to.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      byte_cnt_q   <= '0;
      row_q        <= '0;
      col_q        <= '0;
      weight_q     <= '0;
      wr_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      addr_en_q    <= 1'b0;
      weight_en_q  <= 1'b0;
      rosc_en_q    <= 1'b0;
      sample_clk_q <= 1'b0;
      scan_clk_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      if (wr_accept) begin
        row_q    <= host.i_WR_ROW;
        col_q    <= host.i_WR_COL;
        weight_q <= host.i_WR_DATA;
      end
      wr_ready_q   <= (state_d == ST_IDLE);
      busy_q       <= (state_d != ST_IDLE);
      addr_en_q    <= (state_d == ST_WR_STROBE);
      weight_en_q  <= is_write_state(state_d);
      rosc_en_q    <= (state_d == ST_RUN) || (state_d == ST_SAMPLE);
      sample_clk_q <= (state_d == ST_SAMPLE);
      scan_clk_q   <= (state_d == ST_SCAN_HI);
    end
  end

  // ---------------------------------------------------------------------------
  // Scan deserialiser and result stream
  // ---------------------------------------------------------------------------
  cobi_scan_deser u_deser (
    .clk_i     (i_CLK),
    .rstn_i    (i_RSTN),
    .capture_i (capture),
    .bit_sel_i (bit_idx_q[COBI_BIT_SEL_W-1:0]),
    .dout_i    (i_SCANOUT_DOUT64),
    .load_i    (load),
    .last_i    (byte_cnt_q == COBI_LAST_BYTE),
    .ready_i   (host.i_RES_READY),
    .data_o    (host.o_RES_DATA),
    .valid_o   (host.o_RES_VALID),
    .last_o    (host.o_RES_LAST),
    .accept_o  (res_accept)
  );

  assign host.o_WR_READY = wr_ready_q;
  assign host.o_BUSY     = busy_q;

  assign o_ROW_ADDR    = row_q;
  assign o_COL_ADDR    = col_q;
  assign o_WEIGHT      = weight_q;
  assign o_ADDR_EN64   = addr_en_q;
  assign o_WEIGHT_EN   = weight_en_q;
  assign o_ROSC_EN     = rosc_en_q;
  assign o_SAMPLE_CLK  = sample_clk_q;
  assign o_SCANOUT_CLK = scan_clk_q;
  // Zeros are shifted into the chain behind the captured bits.
  assign o_ALL_ROW_HI  = 1'b0;

endmodule

// File: tb/tb_cobi_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cobi_sequencer
// Drives cobi_sequencer with a behavioural COBI chip (weight memory, sampled
// scan chain) and checks pins and result bytes against expectations derived
// from the weights the bench itself wrote.
// -----------------------------------------------------------------------------
module tb_cobi_sequencer;

  localparam int WR_PULSE     = 2;
  localparam int RUN_CYCLES   = 20;
  localparam int SAMPLE_PULSE = 2;
  localparam int SCAN_HALF    = 2;
  localparam int CHAIN        = 504;
  localparam int NBYTES       = 63;
  localparam int LATENCY      = 1 + RUN_CYCLES + SAMPLE_PULSE + 16 * SCAN_HALF;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cobi_sequencer_if bus ();

  logic [5:0] row_addr, col_addr, weight;
  logic addr_en, weight_en, rosc_en, sample_clk, scan_clk, all_row_hi;
  logic dout;

  cobi_sequencer #(
    .WR_PULSE     (WR_PULSE),
    .RUN_CYCLES   (RUN_CYCLES),
    .SAMPLE_PULSE (SAMPLE_PULSE),
    .SCAN_HALF    (SCAN_HALF)
  ) dut (
    .i_CLK            (clk),
    .i_RSTN           (rstn),
    .host             (bus.slave),
    .o_ROW_ADDR       (row_addr),
    .o_COL_ADDR       (col_addr),
    .o_WEIGHT         (weight),
    .o_ADDR_EN64      (addr_en),
    .o_WEIGHT_EN      (weight_en),
    .o_ROSC_EN        (rosc_en),
    .o_SAMPLE_CLK     (sample_clk),
    .o_SCANOUT_CLK    (scan_clk),
    .o_ALL_ROW_HI     (all_row_hi),
    .i_SCANOUT_DOUT64 (dout)
  );

  // ---------------- behavioural chip ----------------
  logic [5:0] chip_mem [0:4095];
  bit         chain    [0:CHAIN-1];
  int         scan_pos   = 0;
  int         scan_edges = 0;

  always @(posedge clk) if (addr_en === 1'b1) chip_mem[{row_addr, col_addr}] <= weight;

  always @(posedge sample_clk) begin
    for (int i = 0; i < CHAIN; i++) chain[i] = chip_mem[i][0];
    scan_pos = 0;
  end

  always @(posedge scan_clk) begin
    scan_pos++;
    scan_edges++;
  end

  assign dout = (scan_pos < CHAIN) ? chain[scan_pos] : all_row_hi;

  // ---------------- reference: weights the bench intended ----------------
  logic [5:0] wt [0:4095];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = wt[8 * k + j][0];
    return b;
  endfunction

  function automatic logic [35:0] out_vec();
    return {row_addr, col_addr, weight, addr_en, weight_en, rosc_en, sample_clk,
            scan_clk, all_row_hi, bus.o_BUSY, bus.o_RES_VALID, bus.o_RES_LAST,
            bus.o_RES_DATA, bus.o_WR_READY};
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (!(bus.o_WR_READY === 1'b1 && bus.o_BUSY === 1'b0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: busy=%b ready=%b required idle", bus.o_BUSY, bus.o_WR_READY);
    end
  endtask

  task automatic wr(input logic [5:0] r, input logic [5:0] c, input logic [5:0] d);
    @(negedge clk);
    wait_idle();
    bus.i_WR_VALID = 1'b1;
    bus.i_WR_ROW   = r;
    bus.i_WR_COL   = c;
    bus.i_WR_DATA  = d;
    wt[{r, c}]     = d;
    @(negedge clk);
    bus.i_WR_VALID = 1'b0;
    $display("write row=%0d col=%0d data=0x%02h", r, c, d);
  endtask

  // One full run: start, collect 63 bytes, check data/last/edges/latency.
  task automatic do_run(input string tag, input int stall_byte, input int stall_len,
                        input bit rand_ready, input bit glitch, input bit check_lat);
    int got = 0;
    int cyc = 0;
    int first = -1;
    int bad = 0;
    int edges0;
    bit stalled = 1'b0;
    bit glitched = 1'b0;
    bit rdy;
    logic [7:0] d0;
    @(negedge clk);
    wait_idle();
    scan_edges = 0;
    bus.i_START = 1'b1;
    @(negedge clk);
    bus.i_START = 1'b0;
    cyc = 1;
    while (got < NBYTES && cyc < 20000) begin
      bus.i_START = 1'b0;
      if (bus.o_RES_VALID === 1'b1 && first < 0) first = cyc;
      if (glitch && !glitched && got == 20 && bus.o_RES_VALID === 1'b0) begin
        bus.i_START = 1'b1;
        glitched = 1'b1;
      end
      if (bus.o_RES_VALID === 1'b1 && got == stall_byte && !stalled) begin
        stalled = 1'b1;
        d0 = bus.o_RES_DATA;
        edges0 = scan_edges;
        bus.i_RES_READY = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          cyc++;
          n_cmp++;
          if (scan_clk !== 1'b0 || bus.o_RES_VALID !== 1'b1 || bus.o_RES_DATA !== d0 || scan_edges != edges0) begin
            n_err++;
            $display("FAIL %s stall cyc %0d: scan=%b valid=%b data=0x%02h edges=%0d required scan=0 valid=1 data=0x%02h edges=%0d",
                     tag, s, scan_clk, bus.o_RES_VALID, bus.o_RES_DATA, scan_edges, d0, edges0);
          end
        end
      end
      rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.i_RES_READY = rdy;
      if (bus.o_RES_VALID === 1'b1 && rdy) begin
        n_cmp++;
        if (bus.o_RES_DATA !== exp_byte(got) || bus.o_RES_LAST !== (got == NBYTES - 1)) begin
          n_err++;
          $display("FAIL %s byte %0d: data=0x%02h last=%b required data=0x%02h last=%b",
                   tag, got, bus.o_RES_DATA, bus.o_RES_LAST, exp_byte(got), (got == NBYTES - 1));
        end else begin
          $display("%s byte %0d data=0x%02h last=%b", tag, got, bus.o_RES_DATA, bus.o_RES_LAST);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_RES_READY = 1'b0;
    bus.i_START = 1'b0;
    n_cmp++;
    if (got != NBYTES) begin
      n_err++;
      $display("FAIL %s byte_count: got %0d required %0d (cycle budget)", tag, got, NBYTES);
    end
    n_cmp++;
    if (bus.o_BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_after_last: busy=%b required 0", tag, bus.o_BUSY);
    end
    n_cmp++;
    if (scan_edges != CHAIN) begin
      n_err++;
      $display("FAIL %s scan_edges: got %0d required %0d", tag, scan_edges, CHAIN);
    end
    if (check_lat) begin
      n_cmp++;
      if (first != LATENCY) begin
        n_err++;
        $display("FAIL %s latency: got %0d required %0d", tag, first, LATENCY);
      end
    end
    // Nothing further may happen: no extra bytes, no new run.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.o_RES_VALID !== 1'b0 || rosc_en !== 1'b0 || bus.o_BUSY !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s quiet_after_run: %0d active cycles required 0", tag, bad);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_vec() !== 36'h1) begin
      n_err++;
      $display("FAIL reset_values: outputs=0x%09h required 0x%09h", out_vec(), 36'h1);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    logic exp_ae;
    @(negedge clk);
    wait_idle();
    bus.i_WR_VALID = 1'b1;
    bus.i_WR_ROW = 6'd5; bus.i_WR_COL = 6'd9; bus.i_WR_DATA = 6'h2A;
    wt[{6'd5, 6'd9}] = 6'h2A;
    for (int c = 1; c <= WR_PULSE + 3; c++) begin
      @(negedge clk);
      bus.i_WR_VALID = 1'b0;
      n_cmp++;
      if (c <= WR_PULSE + 2) begin
        exp_ae = (c >= 2) && (c <= WR_PULSE + 1);
        if ({row_addr, col_addr, weight, weight_en, addr_en, bus.o_WR_READY} !==
            {6'd5, 6'd9, 6'h2A, 1'b1, exp_ae, 1'b0}) begin
          n_err++;
          $display("FAIL write_cycle %0d: row=%0d col=%0d w=0x%02h wen=%b aen=%b rdy=%b required 5/9/0x2a wen=1 aen=%b rdy=0",
                   c, row_addr, col_addr, weight, weight_en, addr_en, bus.o_WR_READY, exp_ae);
        end
      end else begin
        if ({weight_en, addr_en, bus.o_WR_READY, row_addr} !== {3'b001, 6'd5}) begin
          n_err++;
          $display("FAIL write_done: wen=%b aen=%b rdy=%b row=%0d required wen=0 aen=0 rdy=1 row=5",
                   weight_en, addr_en, bus.o_WR_READY, row_addr);
        end
      end
    end
    n_cmp++;
    if (chip_mem[12'h149] !== 6'h2A) begin
      n_err++;
      $display("FAIL chip_mem_0x149: got 0x%02h required 0x2a", chip_mem[12'h149]);
    end
    $display("write row=5 col=9 data=0x2a checked");
  endtask

  task automatic load_weights(input bit pattern);
    logic [7:0] pat = 8'hA5;
    logic [5:0] d;
    for (int i = 0; i < CHAIN; i++) begin
      d = 6'($urandom);
      if (pattern) d[0] = pat[i % 8];
      wr(6'(i / 64), 6'(i % 64), d);
    end
  endtask

  task automatic test_write_start_collision();
    logic [5:0] d;
    int bad = 0;
    d = 6'($urandom);
    @(negedge clk);
    wait_idle();
    bus.i_WR_VALID = 1'b1; bus.i_START = 1'b1;
    bus.i_WR_ROW = 6'd63; bus.i_WR_COL = 6'd63; bus.i_WR_DATA = d;
    wt[12'hFFF] = d;
    @(negedge clk);
    bus.i_WR_VALID = 1'b0; bus.i_START = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rosc_en !== 1'b0 || sample_clk !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL collision_rosc: %0d cycles with run activity required 0", bad);
    end
    n_cmp++;
    if (chip_mem[12'hFFF] !== d || bus.o_BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL collision_write: mem=0x%02h busy=%b required mem=0x%02h busy=0",
               chip_mem[12'hFFF], bus.o_BUSY, d);
    end
    $display("write row=63 col=63 data=0x%02h with simultaneous start", d);
  endtask

  task automatic test_reset_during_run();
    @(negedge clk);
    wait_idle();
    bus.i_START = 1'b1;
    @(negedge clk);
    bus.i_START = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (rosc_en !== 1'b1) begin
      n_err++;
      $display("FAIL run_rosc: rosc_en=%b required 1", rosc_en);
    end
    rstn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_vec() !== 36'h1) begin
      n_err++;
      $display("FAIL reset_mid_run: outputs=0x%09h required 0x%09h", out_vec(), 36'h1);
    end
    rstn = 1'b1;
    do_run("after_reset", -1, 0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.i_WR_VALID = 1'b0; bus.i_WR_ROW = '0; bus.i_WR_COL = '0; bus.i_WR_DATA = '0;
    bus.i_START = 1'b0; bus.i_RES_READY = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      chip_mem[i] = '0;
      wt[i] = '0;
    end

    test_reset();
    test_single_write();
    load_weights(1'b1);
    do_run("pattern", -1, 0, 1'b0, 1'b0, 1'b1);
    do_run("stall", 10, 50, 1'b0, 1'b0, 1'b0);
    test_write_start_collision();
    do_run("start_glitch", -1, 0, 1'b0, 1'b1, 1'b0);
    test_reset_during_run();
    load_weights(1'b0);
    do_run("random", -1, 0, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cobi_sequencer.md
# cobi_sequencer

Single-clock controller that drives the COBI oscillator array's programming, run and scan-out pins. It accepts weight writes and run commands from the host-side register logic, and generates the weight-latch strobes, ROSC enable, sample pulse and scan clock. It deserialises the 504-bit scan chain into 8-bit result words on a valid/ready stream. It sits between the host interface and the chip pins, and is the only block that toggles chip control signals.

## Interface
- WR_PULSE, default 2: cycles `o_ADDR_EN64` is held high per weight write (≥1).
- RUN_CYCLES, default 1000: cycles `o_ROSC_EN` is high before sampling (≥1, 32-bit count).
- SAMPLE_PULSE, default 2: cycles `o_SAMPLE_CLK` is high (≥1).
- SCAN_HALF, default 2: cycles per half-period of `o_SCANOUT_CLK` (≥1).
- i_CLK  in  1  system clock; all logic on posedge.
- i_RSTN  in  1  reset; **one clock; reset is synchronous and active-low**.
- i_WR_VALID / o_WR_READY  in/out  1  weight-write handshake.
- i_WR_ROW, i_WR_COL, i_WR_DATA  in  6 each  weight address and 6-bit value.
- i_START  in  1  one-cycle run request, accepted only in IDLE.
- o_BUSY  out  1  high in every state except IDLE.
- o_RES_DATA  out  8  result byte; bit j = chain bit 8k+j for byte k.
- o_RES_VALID / i_RES_READY  out/in  1  result stream handshake.
- o_RES_LAST  out  1  high with byte 62, the final byte.
- o_ROW_ADDR, o_COL_ADDR, o_WEIGHT  out  6 each  chip weight bus.
- o_ADDR_EN64, o_WEIGHT_EN, o_ROSC_EN, o_SAMPLE_CLK, o_SCANOUT_CLK, o_ALL_ROW_HI  out  1  chip controls.
- i_SCANOUT_DOUT64  in  1  chip scan-chain output bit.

## Operation
- Reset values: every output 0, except `o_WR_READY`=1. The FSM goes to IDLE.
- Chip outputs are driven from registers only; no combinational paths to the pins.
- `o_ALL_ROW_HI` is tied to 0, so 0 is shifted into the chain.
- FSM states: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RUN, SAMPLE, SCAN_LO, SCAN_HI, EMIT.
- IDLE:
  - Write handshake (`i_WR_VALID & o_WR_READY`): register row, col and data, then go to WR_SETUP.
  - Else `i_START`: go to RUN.
  - If both occur in the same cycle, the write wins and the start is dropped.
- WR_SETUP (1 cycle): address and weight are driven; `o_WEIGHT_EN`=1; `o_ADDR_EN64`=0.
- WR_STROBE (WR_PULSE cycles): `o_ADDR_EN64`=1.
- WR_HOLD (1 cycle): `o_ADDR_EN64`=0, bus still stable. Then go to IDLE.
- In all write states, `o_WEIGHT_EN`=1 and the bus is held stable.
- `o_WR_READY` is 1 only in IDLE.
- Address/weight outputs keep their last value when not writing.
- RUN: `o_ROSC_EN`=1 for RUN_CYCLES cycles, then go to SAMPLE.
- SAMPLE: `o_SAMPLE_CLK`=1 for SAMPLE_PULSE cycles, with `o_ROSC_EN` still 1. Then both go to 0 in the same cycle and the FSM enters SCAN_LO with bit index 0.
- SCAN_LO (SCAN_HALF cycles, clock low):
  - On the last cycle, capture `i_SCANOUT_DOUT64` into shift-register bit (index mod 8).
  - Then go to SCAN_HI.
- SCAN_HI (SCAN_HALF cycles, clock high):
  - Afterwards, increment the bit index.
  - If index mod 8 == 0, go to EMIT; else go to SCAN_LO.
- EMIT:
  - `o_RES_VALID`=1 holding the byte; wait for `i_RES_READY`. The scan clock stays low, so backpressure stalls the chain with no data loss.
  - On handshake: if 504 bits are done, go to IDLE; else go to SCAN_LO.
- `i_START` outside IDLE is ignored; it is not queued.
- Exactly 504 rising edges of `o_SCANOUT_CLK` occur per run.

## Timing
- Write: WR_PULSE+2 cycles from handshake to IDLE; the next write is accepted in the following cycle.
- Run latency, `i_START` to first `o_RES_VALID`: 1 + RUN_CYCLES + SAMPLE_PULSE + 8·2·SCAN_HALF cycles.
- Byte k's valid rises 1 cycle after the 8th high phase of that byte ends.
- Valid/data are stable until accepted.
- Reset low mid-operation: on the next edge, all chip outputs go to 0, the run is abandoned and no partial byte is emitted.
- Counters are sized for the maximum parameter values:
  - Bit index: 9 bits, terminal 503.
  - Byte counter: 6 bits, terminal 62.

## Structure
- `cobi_pkg`: state enum, `COBI_CHAIN_LEN`=504, `COBI_ADDR_W`=6, `COBI_WEIGHT_W`=6, `COBI_RES_W`=8.
- One sub-module, `cobi_scan_deser`:
  - Bit capture, the 8-bit shift register and the byte valid/ready stage.
  - Controlled by capture/emit strobes from the FSM.

## Test plan
- Write row=5, col=9, data=0x2A (WR_PULSE=2):
  - Bus = 5/9/0x2A for 4 cycles.
  - `o_ADDR_EN64` high exactly cycles 2–3.
  - Chip model entry 0x149 = 0x2A.
- Write 504 weights with LSB pattern 0xA5 repeating, then start with `i_RES_READY`=1:
  - 63 bytes, all 0xA5.
  - `o_RES_LAST` only on byte 62.
  - 504 scan edges.
- Same run with `i_RES_READY` low for 50 cycles at byte 10:
  - Scan clock is frozen low during the stall.
  - Data unchanged; bytes 10–62 remain correct.
- `i_WR_VALID` and `i_START` in the same IDLE cycle: only the write executes; `o_ROSC_EN` stays 0.
- `i_START` pulsed during SCAN: no effect; exactly 63 bytes.
- `i_RSTN` low for 1 cycle during RUN:
  - All outputs reset next cycle.
  - A new start produces a full, correct 63-byte result.
